// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential PC generation, jump/branch redirect and
// decode-stall handling over a single-outstanding-request instruction memory.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        jump_control,
    input  logic        branch_taken,
    input  logic [25:0] jump_target,
    input  logic [15:0] branch_offset,
    input  logic [31:0] redir_pc,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic        redirect;
    logic [31:0] redir_target;
    logic        fetch_hit;
    logic        accept;

    function automatic logic [31:0] jump_addr(input logic [31:0] rpc,
                                              input logic [25:0] tgt);
        logic [31:0] seq;
        seq = rpc + 32'd4;
        return {seq[31:28], tgt, 2'b00};
    endfunction

    function automatic logic [31:0] branch_addr(input logic [31:0] rpc,
                                                input logic signed [15:0] off);
        logic signed [31:0] disp;
        disp = {{14{off[15]}}, off, 2'b00};
        return (rpc + 32'd4 + $unsigned(disp)) & ALIGN_MASK;
    endfunction

    assign redirect     = jump_control | branch_taken;
    assign redir_target = jump_control ? jump_addr(redir_pc, jump_target)
                                       : branch_addr(redir_pc, $signed(branch_offset));

    // A stalled decode only accepts a new word when it currently holds nothing.
    assign fetch_hit = (state == FETCH) && imem_ready && !redirect;
    assign accept    = fetch_hit && (!stall || !instr_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (imem_ready && stall) state_nxt = HOLD;
            HOLD:    if (!stall) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
        if (redirect) begin
            state_nxt = FETCH;
        end
    end

    always_comb begin
        imem_req  = (state == FETCH);
        imem_addr = fetch_pc & ALIGN_MASK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC & ALIGN_MASK;
            pc          <= RESET_PC & ALIGN_MASK;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            fetch_pc    <= redir_target;
            instr_valid <= 1'b0;
        end else if (accept) begin
            instr       <= imem_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
            fetch_pc    <= (fetch_pc + 32'(PC_STEP)) & ALIGN_MASK;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; the memory returns {16'hC0DE, addr[15:0]}.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        jump_control;
    logic        branch_taken;
    logic [25:0] jump_target;
    logic [15:0] branch_offset;
    logic [31:0] redir_pc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;

    int checks = 0;
    int errors = 0;
    logic [97:0] obs, exp;

    always #5 clk = ~clk;

    assign imem_rdata = imem_ready ? {16'hC0DE, imem_addr[15:0]} : 32'hDEAD_BEEF;

    ifu_fetch dut (
        .clk(clk), .reset(reset), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .jump_control(jump_control), .branch_taken(branch_taken),
        .jump_target(jump_target), .branch_offset(branch_offset),
        .redir_pc(redir_pc), .pc(pc), .instr(instr), .instr_valid(instr_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_state got %h want %h", obs, exp); end
        reset = 1'b0;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b0, 32'h0, 32'h0, 32'h0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL first_req got %h want %h", obs, exp); end
    endtask

    task automatic test_sequential;
        imem_ready = 1'b1;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'h4, 32'h0, 32'hC0DE_0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL seq_0 got %h want %h", obs, exp); end
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'h8, 32'h4, 32'hC0DE_0004};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL seq_1 got %h want %h", obs, exp); end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = {imem_req, instr_valid, imem_addr, pc, instr};
            exp = {1'b0, 1'b1, 32'h8, 32'h4, 32'hC0DE_0004};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL stall_hold_%0d got %h want %h", i, obs, exp); end
        end
        stall = 1'b0;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'h8, 32'h4, 32'hC0DE_0004};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_release got %h want %h", obs, exp); end
    endtask

    task automatic test_wait;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {imem_req, instr_valid, imem_addr, pc, instr};
            exp = {1'b1, 1'b1, 32'h8, 32'h4, 32'hC0DE_0004};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL wait_%0d got %h want %h", i, obs, exp); end
        end
        imem_ready = 1'b1;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'hC, 32'h8, 32'hC0DE_0008};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL wait_done got %h want %h", obs, exp); end
    endtask

    task automatic test_stall_while_valid;
        imem_ready = 1'b0;
        stall = 1'b1;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'hC, 32'h8, 32'hC0DE_0008};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_nodata got %h want %h", obs, exp); end
        imem_ready = 1'b1;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b0, 1'b1, 32'hC, 32'h8, 32'hC0DE_0008};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_no_overwrite got %h want %h", obs, exp); end
        stall = 1'b0;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'hC, 32'h8, 32'hC0DE_0008};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_refetch got %h want %h", obs, exp); end
    endtask

    task automatic test_jump;
        jump_control = 1'b1;
        redir_pc     = 32'h1000_0010;
        jump_target  = 26'h40;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b0, 32'h1000_0100, 32'h8, 32'hC0DE_0008};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL jump_redirect got %h want %h", obs, exp); end
        jump_control = 1'b0;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'h1000_0104, 32'h1000_0100, 32'hC0DE_0100};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL jump_fetch got %h want %h", obs, exp); end
    endtask

    task automatic test_branch;
        branch_taken  = 1'b1;
        redir_pc      = 32'h20;
        branch_offset = 16'hFFFE;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b0, 32'h1C, 32'h1000_0100, 32'hC0DE_0100};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL branch_drop got %h want %h", obs, exp); end
        branch_taken = 1'b0;
        stall = 1'b1;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b0, 1'b1, 32'h20, 32'h1C, 32'hC0DE_001C};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_capture got %h want %h", obs, exp); end
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_capture_hold got %h want %h", obs, exp); end
        jump_control = 1'b1;
        redir_pc     = 32'h0;
        jump_target  = 26'h3;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b0, 32'hC, 32'h1C, 32'hC0DE_001C};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL redirect_over_stall got %h want %h", obs, exp); end
        jump_control = 1'b0;
        stall = 1'b0;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'h10, 32'hC, 32'hC0DE_000C};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL after_redirect got %h want %h", obs, exp); end
    endtask

    task automatic test_priority;
        jump_control  = 1'b1;
        branch_taken  = 1'b1;
        redir_pc      = 32'h0000_1000;
        jump_target   = 26'h2000;
        branch_offset = 16'h0010;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b0, 32'h8000, 32'hC, 32'hC0DE_000C};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL jump_priority got %h want %h", obs, exp); end
        jump_control = 1'b0;
        branch_taken = 1'b0;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'h8004, 32'h8000, 32'hC0DE_8000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL priority_fetch got %h want %h", obs, exp); end
    endtask

    task automatic test_wrap;
        branch_taken  = 1'b1;
        redir_pc      = 32'h0;
        branch_offset = 16'hFFFE;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b0, 32'hFFFF_FFFC, 32'h8000, 32'hC0DE_8000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL branch_wrap got %h want %h", obs, exp); end
        branch_taken = 1'b0;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hC0DE_FFFC};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL pc_wrap got %h want %h", obs, exp); end
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'h4, 32'h0, 32'hC0DE_0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL post_wrap got %h want %h", obs, exp); end
    endtask

    task automatic test_reset_in_hold;
        stall = 1'b1;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b0, 1'b1, 32'h4, 32'h0, 32'hC0DE_0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL hold_entry got %h want %h", obs, exp); end
        reset        = 1'b1;
        jump_control = 1'b1;
        redir_pc     = 32'h1000_0010;
        jump_target  = 26'h40;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_dominates got %h want %h", obs, exp); end
        reset        = 1'b0;
        jump_control = 1'b0;
        stall        = 1'b0;
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b0, 32'h0, 32'h0, 32'h0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_first_req got %h want %h", obs, exp); end
        tick();
        obs = {imem_req, instr_valid, imem_addr, pc, instr};
        exp = {1'b1, 1'b1, 32'h4, 32'h0, 32'hC0DE_0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_first_data got %h want %h", obs, exp); end
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        imem_ready    = 1'b0;
        jump_control  = 1'b0;
        branch_taken  = 1'b0;
        jump_target   = 26'h0;
        branch_offset = 16'h0;
        redir_pc      = 32'h0;
        tick();
        test_reset();
        test_sequential();
        test_stall();
        test_wait();
        test_stall_while_valid();
        test_jump();
        test_branch();
        test_priority();
        test_wrap();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 4, the sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  decode stage cannot accept; holds the fetch output stable.
REQ-006 imem_req  output  1  instruction memory request valid.
REQ-007 imem_addr  output  32  instruction memory word address (byte address, bits [1:0] = 0).
REQ-008 imem_ready  input  1  memory returns data this cycle for the outstanding request.
REQ-009 imem_rdata  input  32  instruction word; valid only when imem_ready=1.
REQ-010 jump_control  input  1  unconditional jump in decode (j/jal).
REQ-011 branch_taken  input  1  conditional branch resolved taken (beq/bne/bltz outcome).
REQ-012 jump_target  input  26  J-type target field.
REQ-013 branch_offset  input  16  I-type signed word offset.
REQ-014 redir_pc  input  32  PC of the instruction causing the redirect.
REQ-015 pc  output  32  PC of the instruction presented on instr.
REQ-016 instr  output  32  fetched instruction word.
REQ-017 instr_valid  output  1  instr/pc hold a valid instruction for decode.

Function
REQ-018 States: IDLE, FETCH, HOLD; IDLE is entered on reset and lasts exactly one cycle, then FETCH.
REQ-019 FETCH: imem_req=1, imem_addr=fetch_pc; on imem_ready=1 capture imem_rdata into instr, fetch_pc into pc, set instr_valid=1.
REQ-020 FETCH with imem_ready=1 and stall=0: fetch_pc advances by PC_STEP, remain in FETCH (one instruction per cycle throughput at zero wait states).
REQ-021 FETCH with imem_ready=1 and stall=1: capture as REQ-019, advance fetch_pc, go to HOLD.
REQ-022 HOLD: imem_req=0; instr, pc, instr_valid unchanged; return to FETCH the first cycle stall=0.
REQ-023 Stall while FETCH and imem_ready=0: keep imem_req=1 and imem_addr stable; outputs unchanged.
REQ-024 Stall while instr_valid=1 in FETCH without new data: outputs unchanged; instr is never overwritten while stall=1 except as in REQ-021 when instr_valid was 0.
REQ-025 Redirect = jump_control OR branch_taken; jump has priority if both asserted.
REQ-026 Jump target = {redir_pc+4 [31:28], jump_target, 2'b00}.
REQ-027 Branch target = redir_pc + 4 + (sign-extended branch_offset << 2), modulo 2^32 (wrap permitted, no flag).
REQ-028 On redirect (any state): fetch_pc <= target, instr_valid <= 0 next cycle, next state FETCH; redirect overrides stall.
REQ-029 imem_ready arriving in the same cycle as a redirect: data discarded, not captured.
REQ-030 fetch_pc at 32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-031 imem_addr bits [1:0] are always 0; target low bits are forced to 0.
REQ-032 Latency: instruction at address A appears on instr one cycle after the cycle imem_ready=1 for A.

Reset
REQ-033 Reset: state IDLE, fetch_pc=RESET_PC, pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0.
REQ-034 Reset asserted mid-request or in HOLD: pending response discarded; reset dominates redirect and stall.
REQ-035 First request after reset release is RESET_PC, issued in the cycle after IDLE.

Verification
REQ-036 Reset release, imem_ready tied 1, stall=0 -> addresses 0x0,0x4,0x8 requested on consecutive cycles; instr_valid=1 from cycle 3, pc follows one cycle behind.
REQ-037 imem_ready low 3 cycles at address 0x8 -> imem_addr held 0x8, imem_req=1 throughout, instr/pc unchanged until data arrives.
REQ-038 stall=1 for 2 cycles with instr at pc=0x4 -> HOLD, pc=0x4, instr unchanged, imem_req=0; after release next fetch is 0x8.
REQ-039 jump_control=1, redir_pc=0x1000_0010, jump_target=26'h40 -> next imem_addr=0x1000_0100, instr_valid=0 one cycle.
REQ-040 branch_taken=1, redir_pc=0x20, branch_offset=16'hFFFE with imem_ready=1 same cycle -> data dropped, next imem_addr=0x1C.
REQ-041 reset=1 while in HOLD with stall=1 and jump_control=1 -> all outputs at REQ-033 values; first request RESET_PC.
